// File: rtl/ddr3_write_arbiter.sv
// Two-master round-robin arbiter for the shared DDR3 upstream write port.
// Grant is held from the address handshake through the final data beat; LAST is forced at the expected beat.
module ddr3_write_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LEN_W  = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_W-1:0]     M0_WR_ADDR,
    input  logic [LEN_W-1:0]      M0_WR_LEN,
    input  logic [3:0]            M0_WR_ID,
    input  logic                  M0_WR_ADDR_VALID,
    output logic                  M0_WR_ADDR_READY,
    input  logic [DATA_W-1:0]     M0_WR_DATA,
    input  logic [DATA_W/8-1:0]   M0_WR_STRB,
    input  logic                  M0_WR_DATA_VALID,
    input  logic                  M0_WR_DATA_LAST,
    output logic                  M0_WR_DATA_READY,
    output logic [3:0]            M0_WR_BACK_ID,
    input  logic [ADDR_W-1:0]     M1_WR_ADDR,
    input  logic [LEN_W-1:0]      M1_WR_LEN,
    input  logic [3:0]            M1_WR_ID,
    input  logic                  M1_WR_ADDR_VALID,
    output logic                  M1_WR_ADDR_READY,
    input  logic [DATA_W-1:0]     M1_WR_DATA,
    input  logic [DATA_W/8-1:0]   M1_WR_STRB,
    input  logic                  M1_WR_DATA_VALID,
    input  logic                  M1_WR_DATA_LAST,
    output logic                  M1_WR_DATA_READY,
    output logic [3:0]            M1_WR_BACK_ID,
    output logic [ADDR_W-1:0]     WR_ADDR,
    output logic [LEN_W-1:0]      WR_LEN,
    output logic [3:0]            WR_ID,
    output logic                  WR_ADDR_VALID,
    input  logic                  WR_ADDR_READY,
    output logic [DATA_W-1:0]     WR_DATA,
    output logic [DATA_W/8-1:0]   WR_STRB,
    output logic                  WR_DATA_VALID,
    output logic                  WR_DATA_LAST,
    input  logic                  WR_DATA_READY,
    input  logic [3:0]            WR_BACK_ID,
    output logic [1:0]            GRANT,
    output logic                  LEN_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [1:0]         grant_r, grant_nxt_s;
    logic               ptr_r, ptr_nxt_s;
    logic [LEN_W-1:0]   cnt_r, cnt_nxt_s;
    logic               len_err_r, len_err_nxt_s;
    logic [3:0]         back_id0_r, back_id1_r;
    logic               sel1_s;
    logic               sel_addr_valid_s;
    logic               sel_data_valid_s;
    logic               sel_last_s;
    logic [LEN_W-1:0]   sel_len_s;
    logic               cnt_zero_s;
    logic               force_last_s;
    logic               addr_ready_s;
    logic               data_ready_s;

    // ptr_r high means M1 wins the next tie; payload fields follow the owner, valids are gated by state.
    assign sel1_s           = grant_r[1];
    assign sel_addr_valid_s = sel1_s ? M1_WR_ADDR_VALID : M0_WR_ADDR_VALID;
    assign sel_data_valid_s = sel1_s ? M1_WR_DATA_VALID : M0_WR_DATA_VALID;
    assign sel_last_s       = sel1_s ? M1_WR_DATA_LAST  : M0_WR_DATA_LAST;
    assign sel_len_s        = sel1_s ? M1_WR_LEN        : M0_WR_LEN;
    assign cnt_zero_s       = (cnt_r == {LEN_W{1'b0}});
    assign force_last_s     = sel_last_s | cnt_zero_s;

    assign WR_ADDR = sel1_s ? M1_WR_ADDR : M0_WR_ADDR;
    assign WR_LEN  = sel_len_s;
    assign WR_ID   = sel1_s ? M1_WR_ID   : M0_WR_ID;
    assign WR_DATA = sel1_s ? M1_WR_DATA : M0_WR_DATA;
    assign WR_STRB = sel1_s ? M1_WR_STRB : M0_WR_STRB;

    assign M0_WR_ADDR_READY = addr_ready_s & grant_r[0];
    assign M1_WR_ADDR_READY = addr_ready_s & grant_r[1];
    assign M0_WR_DATA_READY = data_ready_s & grant_r[0];
    assign M1_WR_DATA_READY = data_ready_s & grant_r[1];
    assign M0_WR_BACK_ID    = grant_r[0] ? WR_BACK_ID : back_id0_r;
    assign M1_WR_BACK_ID    = grant_r[1] ? WR_BACK_ID : back_id1_r;
    assign GRANT            = grant_r;
    assign LEN_ERR          = len_err_r;

    // Next-state, grant, pointer and beat-counter decisions plus channel handshake gating.
    always_comb begin
        state_nxt_s   = state_r;
        grant_nxt_s   = grant_r;
        ptr_nxt_s     = ptr_r;
        cnt_nxt_s     = cnt_r;
        len_err_nxt_s = 1'b0;
        WR_ADDR_VALID = 1'b0;
        WR_DATA_VALID = 1'b0;
        WR_DATA_LAST  = 1'b0;
        addr_ready_s  = 1'b0;
        data_ready_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (M0_WR_ADDR_VALID && (!M1_WR_ADDR_VALID || !ptr_r)) begin
                    grant_nxt_s = 2'b01;
                    state_nxt_s = ST_ADDR;
                end else if (M1_WR_ADDR_VALID) begin
                    grant_nxt_s = 2'b10;
                    state_nxt_s = ST_ADDR;
                end else begin
                    grant_nxt_s = 2'b00;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                WR_ADDR_VALID = sel_addr_valid_s;
                addr_ready_s  = WR_ADDR_READY;
                if (sel_addr_valid_s && WR_ADDR_READY) begin
                    cnt_nxt_s   = sel_len_s;
                    state_nxt_s = ST_DATA;
                end else begin
                    state_nxt_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                WR_DATA_VALID = sel_data_valid_s;
                WR_DATA_LAST  = force_last_s;
                data_ready_s  = WR_DATA_READY;
                if (sel_data_valid_s && WR_DATA_READY) begin
                    if (force_last_s) begin
                        len_err_nxt_s = (sel_last_s != cnt_zero_s);
                        state_nxt_s   = ST_DONE;
                    end else begin
                        cnt_nxt_s = cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_DONE: begin
                ptr_nxt_s   = grant_r[0];
                grant_nxt_s = 2'b00;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                grant_nxt_s = 2'b00;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Arbiter state, grant, round-robin pointer, beat counter and error pulse registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            grant_r   <= 2'b00;
            ptr_r     <= 1'b0;
            cnt_r     <= {LEN_W{1'b0}};
            len_err_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            grant_r   <= grant_nxt_s;
            ptr_r     <= ptr_nxt_s;
            cnt_r     <= cnt_nxt_s;
            len_err_r <= len_err_nxt_s;
        end
    end

    // Per-master write-back ID hold, refreshed only while that master owns the port.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            back_id0_r <= 4'd0;
            back_id1_r <= 4'd0;
        end else begin
            if (grant_r[0]) begin
                back_id0_r <= WR_BACK_ID;
            end
            if (grant_r[1]) begin
                back_id1_r <= WR_BACK_ID;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_write_arbiter.sv
// Scoreboard bench for ddr3_write_arbiter: request-level round-robin model feeds expectation queues,
// a negedge monitor pops and compares every downstream handshake, LEN_ERR pulse and write-back ID.
module tb_ddr3_write_arbiter;
    localparam int AW = 28;
    localparam int LW = 8;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct {
        int             m;
        logic [AW-1:0]  addr;
        logic [LW-1:0]  len;
        logic [3:0]     id;
        int             last_idx;
        int             nbeats;
        logic [31:0]    base;
    } burst_t;
    typedef struct {
        logic [AW-1:0]  addr;
        logic [LW-1:0]  len;
        logic [3:0]     id;
        logic [1:0]     grant;
    } exp_addr_t;
    typedef struct {
        logic [DW-1:0]  data;
        logic [SW-1:0]  strb;
        logic           last;
    } exp_beat_t;

    logic clk = 1'b0;
    logic rstn;
    logic [1:0][AW-1:0] m_addr;
    logic [1:0][LW-1:0] m_len;
    logic [1:0][3:0]    m_id;
    logic [1:0]         m_avalid;
    logic [1:0][DW-1:0] m_data;
    logic [1:0][SW-1:0] m_strb;
    logic [1:0]         m_dvalid;
    logic [1:0]         m_dlast;
    wire  [1:0]         m_aready;
    wire  [1:0]         m_dready;
    wire  [1:0][3:0]    m_back;
    wire  [AW-1:0]      wr_addr;
    wire  [LW-1:0]      wr_len;
    wire  [3:0]         wr_id;
    wire                wr_avalid;
    logic               wr_aready;
    wire  [DW-1:0]      wr_data;
    wire  [SW-1:0]      wr_strb;
    wire                wr_dvalid;
    wire                wr_dlast;
    logic               wr_dready;
    logic [3:0]         wr_back;
    wire  [1:0]         grant;
    wire                len_err;

    exp_addr_t ea_q[$];
    exp_beat_t eb_q[$];
    bit        ee_q[$];
    burst_t    lst0[$];
    burst_t    lst1[$];
    int n_tests = 0;
    int n_fail  = 0;
    int ptr_m   = 0;
    int a_mode  = 0;
    int d_mode  = 0;

    ddr3_write_arbiter #(.ADDR_W(AW), .LEN_W(LW), .DATA_W(DW)) dut (
        .clk(clk), .rstn(rstn),
        .M0_WR_ADDR(m_addr[0]), .M0_WR_LEN(m_len[0]), .M0_WR_ID(m_id[0]),
        .M0_WR_ADDR_VALID(m_avalid[0]), .M0_WR_ADDR_READY(m_aready[0]),
        .M0_WR_DATA(m_data[0]), .M0_WR_STRB(m_strb[0]), .M0_WR_DATA_VALID(m_dvalid[0]),
        .M0_WR_DATA_LAST(m_dlast[0]), .M0_WR_DATA_READY(m_dready[0]), .M0_WR_BACK_ID(m_back[0]),
        .M1_WR_ADDR(m_addr[1]), .M1_WR_LEN(m_len[1]), .M1_WR_ID(m_id[1]),
        .M1_WR_ADDR_VALID(m_avalid[1]), .M1_WR_ADDR_READY(m_aready[1]),
        .M1_WR_DATA(m_data[1]), .M1_WR_STRB(m_strb[1]), .M1_WR_DATA_VALID(m_dvalid[1]),
        .M1_WR_DATA_LAST(m_dlast[1]), .M1_WR_DATA_READY(m_dready[1]), .M1_WR_BACK_ID(m_back[1]),
        .WR_ADDR(wr_addr), .WR_LEN(wr_len), .WR_ID(wr_id), .WR_ADDR_VALID(wr_avalid),
        .WR_ADDR_READY(wr_aready), .WR_DATA(wr_data), .WR_STRB(wr_strb),
        .WR_DATA_VALID(wr_dvalid), .WR_DATA_LAST(wr_dlast), .WR_DATA_READY(wr_dready),
        .WR_BACK_ID(wr_back), .GRANT(grant), .LEN_ERR(len_err)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [1:0] onehot(input int m);
        return (m == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [DW-1:0] beat_data(input burst_t b, input int i);
        return b.base + 32'(i) * 32'h0100_0193;
    endfunction

    function automatic logic [SW-1:0] beat_strb(input burst_t b, input int i);
        return b.base[3:0] ^ 4'(i);
    endfunction

    function automatic burst_t make_burst(input int m, input int len, input int last_idx);
        burst_t b;
        b.m        = m;
        b.addr     = AW'($urandom);
        b.len      = LW'(len);
        b.id       = 4'($urandom);
        b.last_idx = last_idx;
        b.nbeats   = (last_idx < 0) ? len + 1 : last_idx + 1;
        b.base     = $urandom;
        return b;
    endfunction

    function automatic burst_t rand_burst(input int m);
        int len;
        int mode;
        int li;
        len  = $urandom_range(0, 12);
        mode = $urandom_range(0, 3);
        if (mode == 2 && len > 0) li = $urandom_range(0, len - 1);
        else if (mode == 3) li = -1;
        else li = len;
        return make_burst(m, len, li);
    endfunction

    // Spec-level expectation: the burst ends at the first master LAST or at beat LEN, whichever comes first.
    function automatic void expect_burst(input burst_t b, input int upto);
        exp_addr_t ea;
        exp_beat_t eb;
        int term;
        int n;
        term = (b.last_idx >= 0 && b.last_idx < int'(b.len)) ? b.last_idx : int'(b.len);
        ea.addr  = b.addr;
        ea.len   = b.len;
        ea.id    = b.id;
        ea.grant = onehot(b.m);
        ea_q.push_back(ea);
        n = (upto < 0) ? term + 1 : upto;
        for (int i = 0; i < n; i++) begin
            eb.data = beat_data(b, i);
            eb.strb = beat_strb(b, i);
            eb.last = (i == term);
            eb_q.push_back(eb);
        end
        if (upto < 0) ee_q.push_back((term == b.last_idx) != (term == int'(b.len)));
    endfunction

    task automatic wait_hs(input int m, input bit data_ch);
        int guard;
        bit hs;
        guard = 0;
        hs = 1'b0;
        while (!hs && guard < 6000) begin
            @(negedge clk);
            hs = data_ch ? m_dready[m] : m_aready[m];
            guard++;
        end
        if (!hs) begin
            n_tests++;
            n_fail++;
            $display("FAIL hs_timeout: master %0d channel %0d got no ready within %0d cycles", m, data_ch, guard);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_master(input burst_t b);
        m_addr[b.m]   = b.addr;
        m_len[b.m]    = b.len;
        m_id[b.m]     = b.id;
        m_avalid[b.m] = 1'b1;
        wait_hs(b.m, 1'b0);
        m_avalid[b.m] = 1'b0;
        m_addr[b.m]   = AW'($urandom);
        for (int i = 0; i < b.nbeats; i++) begin
            m_data[b.m]   = beat_data(b, i);
            m_strb[b.m]   = beat_strb(b, i);
            m_dlast[b.m]  = (i == b.last_idx);
            m_dvalid[b.m] = 1'b1;
            wait_hs(b.m, 1'b1);
        end
        m_dvalid[b.m] = 1'b0;
        m_dlast[b.m]  = 1'b0;
        check("grant_done", 64'(grant), 64'(onehot(b.m)));
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
        check("grant_idle", 64'(grant), 64'd0);
    endtask

    // Request-level round robin: each master re-requests immediately, so pending = lists not yet empty.
    task automatic run_round();
        int i0;
        int i1;
        int w;
        i0 = 0;
        i1 = 0;
        while (i0 < lst0.size() || i1 < lst1.size()) begin
            if (i0 < lst0.size() && i1 < lst1.size()) w = ptr_m;
            else w = (i0 < lst0.size()) ? 0 : 1;
            if (w == 0) begin
                expect_burst(lst0[i0], -1);
                i0++;
            end else begin
                expect_burst(lst1[i1], -1);
                i1++;
            end
            ptr_m = 1 - w;
        end
        fork
            begin
                for (int k0 = 0; k0 < lst0.size(); k0++) drive_master(lst0[k0]);
            end
            begin
                for (int k1 = 0; k1 < lst1.size(); k1++) drive_master(lst1[k1]);
            end
        join
        settle();
        lst0.delete();
        lst1.delete();
    endtask

    initial begin
        wr_aready = 1'b1;
        wr_dready = 1'b1;
        wr_back   = 4'd0;
        forever begin
            @(posedge clk);
            #1;
            wr_aready = (a_mode == 0) ? 1'b1 : (a_mode == 1) ? ~wr_aready : ($urandom_range(0, 3) != 0);
            wr_dready = (d_mode == 0) ? 1'b1 : (d_mode == 1) ? ~wr_dready : ($urandom_range(0, 3) != 0);
            wr_back   = 4'($urandom);
        end
    end

    initial begin
        exp_addr_t       ea;
        exp_beat_t       eb;
        bit              err_pend;
        bit              err_val;
        logic [1:0][3:0] exp_back;
        err_pend = 1'b0;
        err_val  = 1'b0;
        exp_back = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                err_pend = 1'b0;
                exp_back = '0;
            end else begin
                if (err_pend) check("len_err_pulse", 64'(len_err), 64'(err_val));
                else check("len_err_quiet", 64'(len_err), 64'd0);
                err_pend = 1'b0;
                for (int m = 0; m < 2; m++) begin
                    if (grant[m]) exp_back[m] = wr_back;
                    check("back_id", 64'(m_back[m]), 64'(exp_back[m]));
                    check("ready_gate", 64'({m_aready[m], m_dready[m]} & {2{~grant[m]}}), 64'd0);
                end
                if (wr_avalid && wr_aready) begin
                    if (ea_q.size() == 0) begin
                        check("addr_unexpected", 64'(wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        ea = ea_q.pop_front();
                        check("wr_addr", 64'(wr_addr), 64'(ea.addr));
                        check("wr_len", 64'(wr_len), 64'(ea.len));
                        check("wr_id", 64'(wr_id), 64'(ea.id));
                        check("grant_addr", 64'(grant), 64'(ea.grant));
                    end
                end
                if (wr_dvalid && wr_dready) begin
                    if (eb_q.size() == 0) begin
                        check("beat_unexpected", 64'(wr_data), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        eb = eb_q.pop_front();
                        check("wr_data", 64'(wr_data), 64'(eb.data));
                        check("wr_strb", 64'(wr_strb), 64'(eb.strb));
                        check("wr_last", 64'(wr_dlast), 64'(eb.last));
                        if (wr_dlast && ee_q.size() != 0) begin
                            err_val  = ee_q.pop_front();
                            err_pend = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        burst_t b;
        rstn     = 1'b0;
        m_addr   = '0;
        m_len    = '0;
        m_id     = '0;
        m_avalid = '0;
        m_data   = '0;
        m_strb   = '0;
        m_dvalid = '0;
        m_dlast  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_valids", 64'({wr_avalid, wr_dvalid, wr_dlast}), 64'd0);
        check("rst_readies", 64'({m_aready, m_dready}), 64'd0);
        check("rst_len_err", 64'(len_err), 64'd0);
        check("rst_back_id", 64'(m_back), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        b = make_burst(0, 3, 3);
        b.addr = 28'h000_0010;
        lst0.push_back(b);
        run_round();

        lst0.push_back(rand_burst(0));
        lst0.push_back(rand_burst(0));
        lst1.push_back(rand_burst(1));
        run_round();
        lst0.push_back(rand_burst(0));
        lst1.push_back(rand_burst(1));
        run_round();

        d_mode = 1;
        lst1.push_back(make_burst(1, 7, 7));
        lst0.push_back(make_burst(0, 2, 2));
        run_round();
        d_mode = 0;

        lst0.push_back(make_burst(0, 5, 2));
        run_round();
        lst1.push_back(make_burst(1, 2, -1));
        run_round();
        check("m1_dready_after", 64'(m_dready[1]), 64'd0);

        lst0.push_back(make_burst(0, 0, 0));
        lst1.push_back(make_burst(1, 0, -1));
        run_round();
        d_mode = 2;
        lst1.push_back(make_burst(1, 255, 255));
        run_round();

        for (int r = 0; r < 30; r++) begin
            int n0;
            int n1;
            a_mode = $urandom_range(0, 2);
            d_mode = $urandom_range(0, 2);
            n0 = $urandom_range(0, 2);
            n1 = $urandom_range(0, 2);
            if (n0 + n1 == 0) n0 = 1;
            for (int k = 0; k < n0; k++) lst0.push_back(rand_burst(0));
            for (int k = 0; k < n1; k++) lst1.push_back(rand_burst(1));
            run_round();
        end

        // Leave the pointer on M1, then abort an M0 burst with reset and confirm M0 wins the next tie.
        a_mode = 0;
        d_mode = 0;
        lst0.push_back(rand_burst(0));
        run_round();
        b = make_burst(0, 7, 7);
        expect_burst(b, 2);
        m_addr[0]   = b.addr;
        m_len[0]    = b.len;
        m_id[0]     = b.id;
        m_avalid[0] = 1'b1;
        wait_hs(0, 1'b0);
        m_avalid[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_data[0]   = beat_data(b, i);
            m_strb[0]   = beat_strb(b, i);
            m_dlast[0]  = 1'b0;
            m_dvalid[0] = 1'b1;
            if (i < 2) wait_hs(0, 1'b1);
        end
        #1;
        rstn = 1'b0;
        #1;
        check("arst_grant", 64'(grant), 64'd0);
        check("arst_valids", 64'({wr_avalid, wr_dvalid, wr_dlast}), 64'd0);
        check("arst_readies", 64'({m_aready, m_dready}), 64'd0);
        check("arst_len_err", 64'(len_err), 64'd0);
        check("arst_back_id", 64'(m_back), 64'd0);
        m_dvalid[0] = 1'b0;
        ptr_m = 0;
        repeat (2) @(posedge clk);
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        lst0.push_back(rand_burst(0));
        lst1.push_back(rand_burst(1));
        run_round();

        repeat (4) @(posedge clk);
        #1;
        check("queues_drained", 64'(ea_q.size() + eb_q.size() + ee_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
